// File: rtl/sync_fifo_if.sv
// Handshake/status bundle for sync_fifo.
// The master side (producer/consumer) drives requests and write data; the
// slave side (the FIFO) drives read data and status flags.
// With SYNC_FIFO_ERR_EN defined the bundle also carries overflow, underflow
// and err_clr.
interface sync_fifo_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  logic                     wr_rq;
  logic [WIDTH-1:0]         wdata;
  logic                     rd_rq;
  logic [WIDTH-1:0]         rdata;
  logic                     rd_valid;
  logic                     full;
  logic                     empty;
  logic                     almost_full;
  logic                     almost_empty;
  logic [$clog2(DEPTH):0]   count;
`ifdef SYNC_FIFO_ERR_EN
  logic                     overflow;
  logic                     underflow;
  logic                     err_clr;

  modport master (
    output wr_rq, wdata, rd_rq, err_clr,
    input  rdata, rd_valid, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  wr_rq, wdata, rd_rq, err_clr,
    output rdata, rd_valid, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
`else
  modport master (
    output wr_rq, wdata, rd_rq,
    input  rdata, rd_valid, full, empty, almost_full, almost_empty, count
  );

  modport slave (
    input  wr_rq, wdata, rd_rq,
    output rdata, rd_valid, full, empty, almost_full, almost_empty, count
  );
`endif
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and registered
// status flags (full/empty/almost_full/almost_empty/count).
// Optional feature macro: SYNC_FIFO_ERR_EN adds sticky overflow/underflow
// flags and an err_clr input through the interface.
// Reset is synchronous and active-low; memory contents survive reset and
// are simply treated as discarded because the pointers and count restart.
module sync_fifo #(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 8,
  parameter int AFULL_THR  = DEPTH - 2,
  parameter int AEMPTY_THR = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  sync_fifo_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [WIDTH-1:0] rdata_q;
  logic             rd_valid_q;
  logic             full_q, empty_q, afull_q, aempty_q;
  logic             wr_acc, rd_acc;

  // Accept decisions use the registered flags, so a read on an empty FIFO
  // or a write on a full one is rejected even if the other side is active.
  always_comb begin
    wr_acc   = bus.wr_rq && !full_q;
    rd_acc   = bus.rd_rq && !empty_q;
    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
  end

  // Storage is written only on accepted writes and never cleared.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem_q[wr_ptr_q] <= bus.wdata;
    end
  end

  // Pointers, occupancy, read port and flags derived from the next count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rdata_q <= mem_q[rd_ptr_q];
      end
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= CW'(AFULL_THR));
      aempty_q <= (count_d <= CW'(AEMPTY_THR));
    end
  end

  assign bus.rdata        = rdata_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, underflow_q;

  // Sticky error flags; a new error event outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_rq && full_q) begin
        overflow_q <= 1'b1;
      end else if (bus.err_clr) begin
        overflow_q <= 1'b0;
      end
      if (bus.rd_rq && empty_q) begin
        underflow_q <= 1'b1;
      end else if (bus.err_clr) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (WIDTH=8, DEPTH=8, AFULL_THR=6,
// AEMPTY_THR=2). A queue-based reference model predicts every output;
// directed scenarios cover the corner cases and a random phase follows.
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;
  int   vectorCount;
  int   missCount;

  sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifoBus ();

  sync_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THR(6), .AEMPTY_THR(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fifoBus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state.
  logic [WIDTH-1:0] modelQ[$];
  logic [WIDTH-1:0] expRdata;
  logic             expValid;
  logic             expOvf;
  logic             expUdf;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed,
               expected, $time);
    end
  endtask

  // Compare every DUT output with the model's prediction.
  task automatic checkAll();
    int n;
    n = modelQ.size();
    checkOutput("count", 32'(fifoBus.count), 32'(n));
    checkOutput("full", 32'(fifoBus.full), 32'(n == DEPTH));
    checkOutput("empty", 32'(fifoBus.empty), 32'(n == 0));
    checkOutput("almost_full", 32'(fifoBus.almost_full), 32'(n >= 6));
    checkOutput("almost_empty", 32'(fifoBus.almost_empty), 32'(n <= 2));
    checkOutput("rd_valid", 32'(fifoBus.rd_valid), 32'(expValid));
    checkOutput("rdata", 32'(fifoBus.rdata), 32'(expRdata));
`ifdef SYNC_FIFO_ERR_EN
    checkOutput("overflow", 32'(fifoBus.overflow), 32'(expOvf));
    checkOutput("underflow", 32'(fifoBus.underflow), 32'(expUdf));
`endif
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then check.
  task automatic applyStimulus(input logic rstn, input logic wr,
                               input logic [WIDTH-1:0] wd, input logic rd,
                               input logic clr);
    bit wasFull, wasEmpty;
    rst_n          = rstn;
    fifoBus.wr_rq  = wr;
    fifoBus.wdata  = wd;
    fifoBus.rd_rq  = rd;
`ifdef SYNC_FIFO_ERR_EN
    fifoBus.err_clr = clr;
`endif
    @(posedge clk);
    if (!rstn) begin
      modelQ.delete();
      expRdata = '0;
      expValid = 1'b0;
      expOvf   = 1'b0;
      expUdf   = 1'b0;
    end else begin
      wasFull  = (modelQ.size() == DEPTH);
      wasEmpty = (modelQ.size() == 0);
      if (wr && wasFull) expOvf = 1'b1;
      else if (clr)      expOvf = 1'b0;
      if (rd && wasEmpty) expUdf = 1'b1;
      else if (clr)       expUdf = 1'b0;
      expValid = rd && !wasEmpty;
      if (expValid) expRdata = modelQ.pop_front();
      if (wr && !wasFull) modelQ.push_back(wd);
    end
    #1;
    checkAll();
  endtask

  initial begin
    logic [WIDTH-1:0] pattern;
    int bias;
    vectorCount = 0;
    missCount   = 0;
    expRdata = '0; expValid = 1'b0; expOvf = 1'b0; expUdf = 1'b0;

    // Reset with requests active: reset must win.
    applyStimulus(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
    // Idle after reset.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    // Write 0x11..0x88, then an extra write of 0x99 that must be dropped.
    for (int i = 1; i <= 8; i++) begin
      pattern = 8'(i * 8'h11);
      applyStimulus(1'b1, 1'b1, pattern, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);

    // Read all 8 words back, then one read on an empty FIFO.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("rdata_hold", 32'(fifoBus.rdata), 32'h88);
    // Clear the sticky errors.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

    // Fill to 4, then 10 cycles of simultaneous read and write (wraps ptrs).
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 8'(8'h40 + i), 1'b1, 1'b0);

    // Drain, then both requests on an empty FIFO.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0);

    // Fill to full, then both requests on a full FIFO.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);

    // Mid-stream reset at count=5, then a read that must be rejected.
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic with a drifting read/write bias and rare resets.
    bias = 50;
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) bias = $urandom_range(20, 80);
      applyStimulus(($urandom_range(0, 79) != 0),
                    ($urandom_range(0, 99) < bias),
                    8'($urandom),
                    ($urandom_range(0, 99) >= bias),
                    ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
